// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter:
// the FSM state encoding and the register-address width.
`default_nettype none

package regfile_port_arbiter_pkg;

   localparam int AW = 5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/regfile_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. It returns the first set
// request at or after ptr, wrapping from N-1 back to 0.
`default_nettype none

module rr_pick
   import regfile_port_arbiter_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] id,
   output logic           any
);

   assign any = |req;

   always_comb begin
      logic [IDW:0] s;
      logic         hit;
      id  = '0;
      s   = '0;
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
         // One extra bit holds ptr+k before it is reduced modulo N.
         s = {1'b0, ptr} + (IDW+1)'(k);
         if (s >= (IDW+1)'(N)) s = s - (IDW+1)'(N);
         if (!hit && req[s[IDW-1:0]]) begin
            hit = 1'b1;
            id  = s[IDW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sharing of the register file's single
// read mux and write port. Each transaction runs IDLE -> ISSUE -> DONE.
`default_nettype none

module regfile_port_arbiter
   import regfile_port_arbiter_pkg::*;
#(
   parameter int DW      = 32,
   parameter int NREQ    = 4,
   parameter int ZERO_R0 = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [AW*NREQ-1:0] req_addr,
   input  logic [DW*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      rf_raddr,
   input  logic [DW-1:0]      rf_rdata,
   output logic               rf_we,
   output logic [AW-1:0]      rf_waddr,
   output logic [DW-1:0]      rf_wdata
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]     state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] cur_id;
   logic           cur_we;
   logic [IDW-1:0] pick_id;
   logic           pick_any;
   logic           sel_we;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_wdata;

   rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
      .req (req),
      .ptr (ptr),
      .id  (pick_id),
      .any (pick_any)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_id == IDW'(i)) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         cur_id   <= '0;
         cur_we   <= 1'b0;
         gnt      <= '0;
         rvalid   <= '0;
         rdata    <= '0;
         rf_raddr <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  cur_id   <= pick_id;
                  cur_we   <= sel_we;
                  gnt      <= NREQ'(1) << pick_id;
                  rf_raddr <= sel_addr;
                  // Writes to r0 are still acknowledged, only the enable is suppressed.
                  if (sel_we) begin
                     rf_waddr <= sel_addr;
                     rf_wdata <= sel_wdata;
                     rf_we    <= !((ZERO_R0 != 0) && (sel_addr == '0));
                  end
                  ptr   <= (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + IDW'(1);
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               gnt    <= '0;
               rf_we  <= 1'b0;
               rvalid <= NREQ'(1) << cur_id;
               if (!cur_we) rdata <= rf_rdata;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               rvalid <= '0;
               state  <= ST_IDLE;
            end
            default: begin
               gnt    <= '0;
               rvalid <= '0;
               rf_we  <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: directed transactions with
// hand-computed grant order and read data, checked by a negedge monitor.
`default_nettype none

module tb_regfile_port_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;

   typedef struct {
      int          id;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        rfwe;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ-1:0]   req_we = '0;
   logic [5*NREQ-1:0] req_addr = '0;
   logic [DW*NREQ-1:0] req_wdata = '0;
   logic [NREQ-1:0]   gnt, rvalid, gnt_b, rvalid_b;
   logic [DW-1:0]     rdata, rdata_b;
   logic [4:0]        rf_raddr, rf_waddr, rf_raddr_b, rf_waddr_b;
   logic [DW-1:0]     rf_rdata, rf_wdata, rf_wdata_b;
   logic [DW-1:0]     rf_rdata_b = '0;
   logic              rf_we, rf_we_b;

   logic [31:0] rf [32];
   exp_t gq[$];
   exp_t vq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_gnt = -1;

   logic        c_we   [NREQ][4];
   logic [4:0]  c_addr [NREQ][4];
   logic [31:0] c_data [NREQ][4];
   int          n_cmd  [NREQ];

   regfile_port_arbiter #(.DW(DW), .NREQ(NREQ), .ZERO_R0(1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
      .rvalid(rvalid), .rdata(rdata), .rf_raddr(rf_raddr),
      .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata)
   );

   // Same stimulus with r0 protection off; only its write enable is observed.
   regfile_port_arbiter #(.DW(DW), .NREQ(NREQ), .ZERO_R0(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_b),
      .rvalid(rvalid_b), .rdata(rdata_b), .rf_raddr(rf_raddr_b),
      .rf_rdata(rf_rdata_b), .rf_we(rf_we_b), .rf_waddr(rf_waddr_b),
      .rf_wdata(rf_wdata_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rf_rdata = rf[rf_raddr];

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'hF000_0000 | i;
      forever begin
         @(posedge clk);
         if (rf_we) rf[rf_waddr] <= rf_wdata;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
      tests++;
      if (act !== req_v) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req_v);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt != '0) begin
            if (gq.size() == 0) begin
               tests++; fails++;
               $display("FAIL gnt_unexpected: got %b, required none", gnt);
            end else begin
               exp_t e;
               logic [NREQ-1:0] oh;
               e  = gq.pop_front();
               oh = NREQ'(1) << e.id;
               chk("gnt_onehot", 64'(gnt), 64'(oh));
               chk("rf_raddr", 64'(rf_raddr), 64'(e.addr));
               chk("rf_we", 64'(rf_we), 64'(e.rfwe));
               if (e.rfwe) begin
                  chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                  chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
               end
               if (e.we && e.addr == 5'd0) chk("rf_we_r0_unprotected", 64'(rf_we_b), 64'd1);
               if (last_gnt >= 0) chk("gnt_spacing", 64'(cyc - last_gnt), 64'd3);
               last_gnt = cyc;
            end
         end
         if (rvalid != '0) begin
            if (vq.size() == 0) begin
               tests++; fails++;
               $display("FAIL rvalid_unexpected: got %b, required none", rvalid);
            end else begin
               exp_t e;
               logic [NREQ-1:0] oh;
               e  = vq.pop_front();
               oh = NREQ'(1) << e.id;
               chk("rvalid_onehot", 64'(rvalid), 64'(oh));
               if (!e.we) chk("rdata", 64'(rdata), 64'(e.data));
            end
         end
      end
   end

   task automatic expect_txn(input int id, input logic we, input logic [4:0] a,
                             input logic [31:0] d, input logic rfwe, input logic has_rv);
      exp_t e;
      e.id = id; e.we = we; e.addr = a; e.data = d; e.rfwe = rfwe;
      gq.push_back(e);
      if (has_rv) vq.push_back(e);
   endtask

   task automatic set_cmd(input int i, input logic we, input logic [4:0] a, input logic [31:0] d);
      req_we[i]           = we;
      req_addr[5*i +: 5]  = a;
      req_wdata[DW*i +: DW] = d;
   endtask

   task automatic add_cmd(input int i, input logic we, input logic [4:0] a, input logic [31:0] d);
      c_we[i][n_cmd[i]]   = we;
      c_addr[i][n_cmd[i]] = a;
      c_data[i][n_cmd[i]] = d;
      n_cmd[i]++;
   endtask

   task automatic wait_gnt(input int i);
      int guard = 0;
      while (!gnt[i] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!gnt[i]) begin
         tests++; fails++;
         $display("FAIL wait_gnt_timeout: got no gnt[%0d], required one within 50 cycles", i);
      end
   endtask

   // Each requester plays its command list, keeping req high between grants.
   task automatic run();
      int cnt [NREQ];
      int guard = 0;
      last_gnt = -1;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         cnt[i] = 0;
         if (n_cmd[i] > 0) begin
            set_cmd(i, c_we[i][0], c_addr[i][0], c_data[i][0]);
            req[i] = 1'b1;
         end
      end
      while (req != '0 && guard < 200) begin
         @(negedge clk);
         guard++;
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && req[i]) begin
               cnt[i]++;
               if (cnt[i] == n_cmd[i]) req[i] = 1'b0;
               else set_cmd(i, c_we[i][cnt[i]], c_addr[i][cnt[i]], c_data[i][cnt[i]]);
            end
         end
      end
      if (req != '0) begin
         tests++; fails++;
         $display("FAIL run_timeout: got req=%b still pending, required all granted", req);
         req = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NREQ; i++) n_cmd[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) n_cmd[i] = 0;

      repeat (2) @(negedge clk);
      chk("reset_gnt", 64'(gnt), 64'd0);
      chk("reset_rvalid", 64'(rvalid), 64'd0);
      chk("reset_rf_we", 64'(rf_we), 64'd0);
      chk("reset_rdata", 64'(rdata), 64'd0);
      chk("reset_rf_raddr", 64'(rf_raddr), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Write to r5 aborted by reset while in ISSUE.
      last_gnt = -1;
      expect_txn(1, 1'b1, 5'd5, 32'h0000_0055, 1'b1, 1'b0);
      set_cmd(1, 1'b1, 5'd5, 32'h0000_0055);
      req[1] = 1'b1;
      @(negedge clk);
      wait_gnt(1);
      req[1] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_gnt", 64'(gnt), 64'd0);
      chk("async_reset_rvalid", 64'(rvalid), 64'd0);
      chk("async_reset_rf_we", 64'(rf_we), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Round robin from ptr=0: writes then reads of r10..r13.
      for (int i = 0; i < NREQ; i++) begin
         add_cmd(i, 1'b1, 5'(10 + i), 32'hA0 + i);
         expect_txn(i, 1'b1, 5'(10 + i), 32'hA0 + i, 1'b1, 1'b1);
      end
      run();
      for (int i = 0; i < NREQ; i++) begin
         add_cmd(i, 1'b0, 5'(10 + i), 32'h0);
         expect_txn(i, 1'b0, 5'(10 + i), 32'hA0 + i, 1'b0, 1'b1);
      end
      run();

      // Requester 2: write then read r7, req held across the first grant.
      add_cmd(2, 1'b1, 5'd7, 32'hDEAD_BEEF);
      add_cmd(2, 1'b0, 5'd7, 32'h0);
      expect_txn(2, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1);
      expect_txn(2, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1);
      run();

      // ptr=3 with req=0101: wraps to 0, skips 1, then 2.
      add_cmd(0, 1'b0, 5'd10, 32'h0);
      add_cmd(2, 1'b0, 5'd12, 32'h0);
      expect_txn(0, 1'b0, 5'd10, 32'hA0, 1'b0, 1'b1);
      expect_txn(2, 1'b0, 5'd12, 32'hA2, 1'b0, 1'b1);
      run();

      // ptr back at 3: full request starts at requester 3.
      for (int i = 0; i < NREQ; i++) add_cmd(i, 1'b0, 5'(10 + i), 32'h0);
      expect_txn(3, 1'b0, 5'd13, 32'hA3, 1'b0, 1'b1);
      expect_txn(0, 1'b0, 5'd10, 32'hA0, 1'b0, 1'b1);
      expect_txn(1, 1'b0, 5'd11, 32'hA1, 1'b0, 1'b1);
      expect_txn(2, 1'b0, 5'd12, 32'hA2, 1'b0, 1'b1);
      run();

      // r0 write dropped; r0 and the aborted r5 keep their original contents.
      add_cmd(1, 1'b1, 5'd0, 32'h0000_1234);
      add_cmd(1, 1'b0, 5'd0, 32'h0);
      add_cmd(1, 1'b0, 5'd5, 32'h0);
      expect_txn(1, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1);
      expect_txn(1, 1'b0, 5'd0, 32'hF000_0000, 1'b0, 1'b1);
      expect_txn(1, 1'b0, 5'd5, 32'hF000_0005, 1'b0, 1'b1);
      run();

      // Requester 3 pulses req only while requester 0 is past IDLE.
      last_gnt = -1;
      expect_txn(0, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1);
      set_cmd(0, 1'b0, 5'd7, 32'h0);
      req[0] = 1'b1;
      @(negedge clk);
      wait_gnt(0);
      req[0] = 1'b0;
      set_cmd(3, 1'b0, 5'd13, 32'h0);
      req[3] = 1'b1;
      @(negedge clk);
      req[3] = 1'b0;
      repeat (6) @(negedge clk);

      add_cmd(3, 1'b0, 5'd13, 32'h0);
      expect_txn(3, 1'b0, 5'd13, 32'hA3, 1'b0, 1'b1);
      run();

      chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
      chk("rvalid_queue_drained", 64'(vq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
